// File: rtl/elbeth_demux_1_to_4_pkg.sv
// Shared definitions for the elbeth 1-to-4 demultiplexer.
// Holds select/state encodings, widths and a select-to-one-hot helper.
// Optional feature macro: ELBETH_DEMUX_STATS_EN (uses the stat widths below).
package elbeth_demux_1_to_4_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned N_CH         = 4;
  localparam int unsigned STAT_CNT_W   = 16;
  localparam int unsigned STAT_FLUSH_W = 8;

  // Destination select encodings
  localparam logic [SEL_W-1:0] SEL_CH1 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CH2 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_CH3 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_CH4 = 2'b11;

  // Output stage occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Channel one-hot for a select value (bit 0 = ch1)
  function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_CH1: oh = 4'b0001;
      SEL_CH2: oh = 4'b0010;
      SEL_CH3: oh = 4'b0100;
      SEL_CH4: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/elbeth_demux_1_to_4_if.sv
// Handshake bundle for the elbeth 1-to-4 demultiplexer.
// Upstream: flush, in_data, in_sel, in_valid -> in_ready.
// Downstream: demux_out_n, out_valid_n -> out_ready_n (n = 1..4); busy status.
// slave modport = demux view, master modport = upstream/downstream environment.
interface elbeth_demux_1_to_4_if
  import elbeth_demux_1_to_4_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] demux_out_1;
  logic [DATA_W-1:0] demux_out_2;
  logic [DATA_W-1:0] demux_out_3;
  logic [DATA_W-1:0] demux_out_4;
  logic              out_valid_1;
  logic              out_valid_2;
  logic              out_valid_3;
  logic              out_valid_4;
  logic              out_ready_1;
  logic              out_ready_2;
  logic              out_ready_3;
  logic              out_ready_4;

  logic              busy;

  modport slave (
    input  flush, in_data, in_sel, in_valid,
    output in_ready,
    output demux_out_1, demux_out_2, demux_out_3, demux_out_4,
    output out_valid_1, out_valid_2, out_valid_3, out_valid_4,
    input  out_ready_1, out_ready_2, out_ready_3, out_ready_4,
    output busy
  );

  modport master (
    output flush, in_data, in_sel, in_valid,
    input  in_ready,
    input  demux_out_1, demux_out_2, demux_out_3, demux_out_4,
    input  out_valid_1, out_valid_2, out_valid_3, out_valid_4,
    output out_ready_1, out_ready_2, out_ready_3, out_ready_4,
    input  busy
  );

endinterface

// File: rtl/elbeth_demux_1_to_4_stats.sv
// Delivery/discard statistics for the elbeth 1-to-4 demultiplexer.
// Ports: clk, rst_n; drain + drain_sel (a word left on that channel);
//   flush_discard (a flush dropped a held word);
//   stat_cnt_1..4 (16-bit, wrapping), stat_flush_cnt (8-bit, wrapping).
// Only instantiated when ELBETH_DEMUX_STATS_EN is defined. Flush does not clear it.
module elbeth_demux_1_to_4_stats
  import elbeth_demux_1_to_4_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    drain,
  input  logic [SEL_W-1:0]        drain_sel,
  input  logic                    flush_discard,
  output logic [STAT_CNT_W-1:0]   stat_cnt_1,
  output logic [STAT_CNT_W-1:0]   stat_cnt_2,
  output logic [STAT_CNT_W-1:0]   stat_cnt_3,
  output logic [STAT_CNT_W-1:0]   stat_cnt_4,
  output logic [STAT_FLUSH_W-1:0] stat_flush_cnt
);

  logic [STAT_CNT_W-1:0]   cnt_q [N_CH];
  logic [STAT_CNT_W-1:0]   cnt_d [N_CH];
  logic [STAT_FLUSH_W-1:0] flush_cnt_q;
  logic [STAT_FLUSH_W-1:0] flush_cnt_d;

  // Next counter values; natural overflow gives the wrap
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i] = cnt_q[i];
    end
    flush_cnt_d = flush_cnt_q;
    if (drain) begin
      cnt_d[drain_sel] = cnt_q[drain_sel] + STAT_CNT_W'(1);
    end
    if (flush_discard) begin
      flush_cnt_d = flush_cnt_q + STAT_FLUSH_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
      end
      flush_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stat_cnt_1     = cnt_q[0];
  assign stat_cnt_2     = cnt_q[1];
  assign stat_cnt_3     = cnt_q[2];
  assign stat_cnt_4     = cnt_q[3];
  assign stat_flush_cnt = flush_cnt_q;

endmodule

// File: rtl/elbeth_demux_1_to_4.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes.
// One output stage holds a word and presents it on the channel chosen by the
// select captured at accept, until that channel's ready drains it.
// Ports: clk, rst_n (async, active low); bus (elbeth_demux_1_to_4_if.slave):
//   flush, in_data, in_sel, in_valid, in_ready, demux_out_1..4,
//   out_valid_1..4, out_ready_1..4, busy.
// Optional: ELBETH_DEMUX_STATS_EN adds stat_cnt_1..4 and stat_flush_cnt.
// in_ready is combinational from flush and the selected out_ready only.
module elbeth_demux_1_to_4
  import elbeth_demux_1_to_4_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  elbeth_demux_1_to_4_if.slave    bus
`ifdef ELBETH_DEMUX_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0]   stat_cnt_1,
  output logic [STAT_CNT_W-1:0]   stat_cnt_2,
  output logic [STAT_CNT_W-1:0]   stat_cnt_3,
  output logic [STAT_CNT_W-1:0]   stat_cnt_4,
  output logic [STAT_FLUSH_W-1:0] stat_flush_cnt
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   vld_q, vld_d;

  logic [N_CH-1:0]   ready_vec;
  logic              drain_c;
  logic              in_ready_c;
  logic              accept_c;

  assign ready_vec = {bus.out_ready_4, bus.out_ready_3, bus.out_ready_2, bus.out_ready_1};

  // Handshake decode; only the selected channel's ready can drain
  always_comb begin
    drain_c    = (state_q == ST_FULL) && ready_vec[sel_q];
    in_ready_c = !bus.flush && ((state_q == ST_EMPTY) || drain_c);
    accept_c   = bus.in_valid && in_ready_c;
  end

  // Next-state and held-word logic; flush wins over drain and accept
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d = ST_FULL;
            data_d  = bus.in_data;
            sel_d   = bus.in_sel;
          end
        end
        ST_FULL: begin
          if (accept_c) begin
            data_d = bus.in_data;
            sel_d  = bus.in_sel;
          end else if (drain_c) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    vld_d = (state_d == ST_FULL) ? sel_onehot(sel_d) : '0;
  end

  // Output stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= SEL_CH1;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
    end
  end

  // Unselected channels are forced to zero so they never show stale data
  assign bus.out_valid_1 = vld_q[0];
  assign bus.out_valid_2 = vld_q[1];
  assign bus.out_valid_3 = vld_q[2];
  assign bus.out_valid_4 = vld_q[3];
  assign bus.demux_out_1 = vld_q[0] ? data_q : '0;
  assign bus.demux_out_2 = vld_q[1] ? data_q : '0;
  assign bus.demux_out_3 = vld_q[2] ? data_q : '0;
  assign bus.demux_out_4 = vld_q[3] ? data_q : '0;
  assign bus.busy        = (state_q == ST_FULL);
  assign bus.in_ready    = in_ready_c;

`ifdef ELBETH_DEMUX_STATS_EN
  elbeth_demux_1_to_4_stats u_stats (
    .clk            (clk),
    .rst_n          (rst_n),
    .drain          (drain_c),
    .drain_sel      (sel_q),
    .flush_discard  (bus.flush && (state_q == ST_FULL)),
    .stat_cnt_1     (stat_cnt_1),
    .stat_cnt_2     (stat_cnt_2),
    .stat_cnt_3     (stat_cnt_3),
    .stat_cnt_4     (stat_cnt_4),
    .stat_flush_cnt (stat_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_elbeth_demux_1_to_4.sv
// Directed bench for elbeth_demux_1_to_4: reference model + scoreboard queue.
module tb_elbeth_demux_1_to_4;
  import elbeth_demux_1_to_4_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  elbeth_demux_1_to_4_if #(.DATA_W(32)) bus();

`ifdef ELBETH_DEMUX_STATS_EN
  logic [15:0] stat_cnt_1, stat_cnt_2, stat_cnt_3, stat_cnt_4;
  logic [7:0]  stat_flush_cnt;
`endif

  elbeth_demux_1_to_4 #(.DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef ELBETH_DEMUX_STATS_EN
    ,
    .stat_cnt_1     (stat_cnt_1),
    .stat_cnt_2     (stat_cnt_2),
    .stat_cnt_3     (stat_cnt_3),
    .stat_cnt_4     (stat_cnt_4),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_acc = 0;

  // Reference model of the output stage
  bit          m_full;
  logic [1:0]  m_sel;
  logic [31:0] m_data;
`ifdef ELBETH_DEMUX_STATS_EN
  int unsigned m_cnt [4];
  int unsigned m_fcnt;
`endif

  logic [3:0]  obs_vld;
  logic [31:0] obs_dat [4];
  assign obs_vld    = {bus.out_valid_4, bus.out_valid_3, bus.out_valid_2, bus.out_valid_1};
  assign obs_dat[0] = bus.demux_out_1;
  assign obs_dat[1] = bus.demux_out_2;
  assign obs_dat[2] = bus.demux_out_3;
  assign obs_dat[3] = bus.demux_out_4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  task automatic set_ready(input logic [3:0] r);
    bus.out_ready_1 = r[0];
    bus.out_ready_2 = r[1];
    bus.out_ready_3 = r[2];
    bus.out_ready_4 = r[3];
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_sel  = 2'b00;
    m_data = '0;
    sb_q.delete();
`ifdef ELBETH_DEMUX_STATS_EN
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_fcnt = 0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    set_ready(4'b0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One cycle: check outputs against the model, score deliveries, advance model
  task automatic tick();
    logic [3:0] rv;
    logic       drain, exp_rdy, acc, sel_hit;
    sb_t        e;
    #1;
    rv      = {bus.out_ready_4, bus.out_ready_3, bus.out_ready_2, bus.out_ready_1};
    drain   = m_full && rv[m_sel];
    exp_rdy = !bus.flush && (!m_full || drain);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("busy", bus.busy, m_full);
    for (int n = 0; n < 4; n++) begin
      sel_hit = m_full && (m_sel == 2'(n));
      chk("out_valid", obs_vld[n], sel_hit);
      chk("demux_out", obs_dat[n], sel_hit ? m_data : 32'h0);
      if (obs_vld[n] && rv[n]) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_word", 64'(n + 1), 64'h0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_channel", 64'(n), 64'(e.ch));
          chk("sb_data", obs_dat[n], e.data);
        end
      end
    end
    if (bus.flush && m_full && !drain && sb_q.size() > 0) void'(sb_q.pop_front());
`ifdef ELBETH_DEMUX_STATS_EN
    if (drain) m_cnt[m_sel]++;
    if (bus.flush && m_full) m_fcnt++;
`endif
    acc = bus.in_valid && exp_rdy;
    if (acc) begin
      sb_q.push_back('{ch: bus.in_sel, data: bus.in_data});
      n_acc++;
    end
    if (bus.flush) m_full = 1'b0;
    else if (acc) begin
      m_full = 1'b1;
      m_sel  = bus.in_sel;
      m_data = bus.in_data;
    end else if (drain) m_full = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    rst_n = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    set_ready(4'b0000);
    #2;
    do_reset();

    // Reset state
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    tick();

    // Asynchronous reset while FULL on ch3
    drive(1'b1, 2'b10, 32'hDEADBEEF);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("full_valid3", bus.out_valid_3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid3", bus.out_valid_3, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_data3", bus.demux_out_3, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single transfer to ch2
    drive(1'b1, 2'b01, 32'h12345678);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    chk("single_data2", bus.demux_out_2, 32'h12345678);
    tick();
    set_ready(4'b0010);
    tick();
    set_ready(4'b0000);
    chk("single_empty", bus.busy, 1'b0);
    tick();

    // Backpressure on ch4 while other channels are ready
    drive(1'b1, 2'b11, 32'hA1A1A1A1);
    tick();
    drive(1'b1, 2'b00, 32'hB2B2B2B2);
    set_ready(4'b0111);
    a0 = n_acc;
    repeat (5) tick();
    chk("bp_no_accept", 64'(n_acc - a0), 64'd0);
    chk("bp_data4_stable", bus.demux_out_4, 32'hA1A1A1A1);
    set_ready(4'b1111);
    tick();
    chk("bp_same_cycle_accept", 64'(n_acc - a0), 64'd1);
    drive(1'b0, 2'b00, 32'h0);
    tick();
    tick();

    // Streaming: one word per cycle, select cycling through channels
    set_ready(4'b1111);
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 32'hA0000000 + 32'(i));
      tick();
    end
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("stream_accepts", 64'(n_acc - a0), 64'd8);
    chk("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    // Flush colliding with drain and a pending offer
    set_ready(4'b0000);
    drive(1'b1, 2'b00, 32'hC1C1C1C1);
    tick();
    drive(1'b1, 2'b01, 32'hC2C2C2C2);
    tick();
    set_ready(4'b0001);
    bus.flush = 1'b1;
    a0 = n_acc;
    tick();
    chk("flush_no_accept", 64'(n_acc - a0), 64'd0);
    bus.flush = 1'b0;
    tick();
    chk("flush_then_accept", 64'(n_acc - a0), 64'd1);
    drive(1'b0, 2'b00, 32'h0);
    set_ready(4'b1111);
    tick();
    tick();

`ifdef ELBETH_DEMUX_STATS_EN
    // Counter wrap on ch1 and flush discard counting
    do_reset();
    set_ready(4'b1111);
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, 2'b00, 32'(i));
      tick();
    end
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("stat_cnt_1_wrap", stat_cnt_1, 16'd4464);
    chk("stat_cnt_1_model", stat_cnt_1, 16'(m_cnt[0]));
    chk("stat_cnt_2", stat_cnt_2, 16'(m_cnt[1]));
    chk("stat_cnt_3", stat_cnt_3, 16'(m_cnt[2]));
    chk("stat_cnt_4", stat_cnt_4, 16'(m_cnt[3]));
    set_ready(4'b0000);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b10, 32'hF0000000 + 32'(k));
      tick();
      drive(1'b0, 2'b00, 32'h0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    chk("stat_flush_cnt", stat_flush_cnt, 8'd3);
    chk("stat_flush_model", stat_flush_cnt, 8'(m_fcnt));
    chk("stat_cnt_1_kept", stat_cnt_1, 16'd4464);
`endif

    chk("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
